rv_mc_ctrl: RTL

- Multi-cycle RV32I control unit; the initiator side of the ALU operation interface.
- Decodes the instruction register, sequences IF/ID/EX/MEM/WB, and drives ALU_OP plus datapath write enables and mux selects.
- Consumes ZF back from the ALU for branch resolution.
- Sits between the IR/PC/register-file datapath and the ALU in the multi-cycle CPU top.

---
 rtl/rv_mc_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB and drives ALU_OP, enables and mux selects.
// Optional macro RV_MC_ILLEGAL_TRAP_EN: illegal opcodes trap into S_HALT instead of retiring as NOPs.
module rv_mc_ctrl #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        inst,
   input  logic               ZF,
   output logic [3:0]         ALU_OP,
   output logic               PC_Write,
   output logic               PC0_Write,
   output logic               IR_Write,
   output logic               AB_Write,
   output logic               F_Write,
   output logic               MDR_Write,
   output logic               Reg_Write,
   output logic               Mem_Write,
   output logic [1:0]         rs2_imm_s,
   output logic               alu_a_s,
   output logic [1:0]         w_data_s,
   output logic [1:0]         PC_s,
   output logic               HALT,
   output logic [STATE_W-1:0] DBG_STATE
);

   typedef enum logic [STATE_W-1:0] {
      S_IF    = 'd0,  S_ID  = 'd1,  S_EXR = 'd2,  S_EXI  = 'd3,
      S_WB    = 'd4,  S_LUI = 'd5,  S_MADDR = 'd6, S_MRD = 'd7,
      S_LWB   = 'd8,  S_MWR = 'd9,  S_BR  = 'd10, S_JAL  = 'd11,
      S_JALR  = 'd12, S_JWB = 'd13, S_HALT = 'd14
   } state_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       pc_write, pc0_write, ir_write, ab_write;
      logic       f_write, mdr_write, reg_write, mem_write;
      logic [1:0] rs2_imm_s;
      logic       alu_a_s;
      logic [1:0] w_data_s, pc_s;
      logic       halt;
   } ctl_t;

   state_t     state, state_nx;
   ctl_t       ctl;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_inst_bits;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IF;
      else     state <= state_nx;
   end

   // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
   always_comb begin
      ctl      = '0;
      state_nx = S_IF;
      unique case (state)
         S_IF: begin
            ctl.ir_write  = 1'b1;
            ctl.pc0_write = 1'b1;
            ctl.pc_write  = 1'b1;
            state_nx      = S_ID;
         end
         S_ID: begin
            ctl.ab_write = 1'b1;
            case (opcode)
               7'b0110011:             state_nx = S_EXR;
               7'b0010011:             state_nx = S_EXI;
               7'b0110111:             state_nx = S_LUI;
               7'b0000011, 7'b0100011: state_nx = S_MADDR;
               7'b1100011:             state_nx = S_BR;
               7'b1101111:             state_nx = S_JAL;
               7'b1100111:             state_nx = S_JALR;
`ifdef RV_MC_ILLEGAL_TRAP_EN
               default:                state_nx = S_HALT;
`else
               default:                state_nx = S_IF;
`endif
            endcase
         end
         S_EXR: begin
            ctl.alu_op  = {inst[30], funct3};
            ctl.f_write = 1'b1;
            state_nx    = S_WB;
         end
         S_EXI: begin
            // Only shifts use inst[30] as an opcode bit; elsewhere it belongs to the immediate.
            ctl.alu_op    = (funct3 == 3'b101) ? {inst[30], 3'b101} : {1'b0, funct3};
            ctl.rs2_imm_s = 2'd1;
            ctl.f_write   = 1'b1;
            state_nx      = S_WB;
         end
         S_WB: begin
            ctl.reg_write = 1'b1;
            state_nx      = S_IF;
         end
         S_LUI: begin
            ctl.reg_write = 1'b1;
            ctl.w_data_s  = 2'd1;
            state_nx      = S_IF;
         end
         S_MADDR: begin
            ctl.rs2_imm_s = 2'd1;
            ctl.f_write   = 1'b1;
            state_nx      = opcode[5] ? S_MWR : S_MRD;
         end
         S_MRD: begin
            ctl.mdr_write = 1'b1;
            state_nx      = S_LWB;
         end
         S_LWB: begin
            ctl.reg_write = 1'b1;
            ctl.w_data_s  = 2'd2;
            state_nx      = S_IF;
         end
         S_MWR: begin
            ctl.mem_write = 1'b1;
            state_nx      = S_IF;
         end
         S_BR: begin
            ctl.alu_op   = 4'b1000;
            ctl.pc_s     = 2'd1;
            ctl.pc_write = ((funct3 == 3'b000) & ZF) | ((funct3 == 3'b001) & ~ZF);
            state_nx     = S_IF;
         end
         S_JAL: begin
            ctl.reg_write = 1'b1;
            ctl.w_data_s  = 2'd3;
            ctl.pc_write  = 1'b1;
            ctl.pc_s      = 2'd1;
            state_nx      = S_IF;
         end
         S_JALR: begin
            ctl.rs2_imm_s = 2'd1;
            ctl.f_write   = 1'b1;
            state_nx      = S_JWB;
         end
         S_JWB: begin
            ctl.reg_write = 1'b1;
            ctl.w_data_s  = 2'd3;
            ctl.pc_write  = 1'b1;
            ctl.pc_s      = 2'd2;
            state_nx      = S_IF;
         end
`ifdef RV_MC_ILLEGAL_TRAP_EN
         S_HALT: begin
            ctl.halt = 1'b1;
            state_nx = S_HALT;
         end
`endif
         default: state_nx = S_IF;
      endcase
   end

   // Reset masks every control output so an abandoned instruction cannot write anything.
   ctl_t ctl_out;
   assign ctl_out = rst ? '0 : ctl;

   assign ALU_OP    = ctl_out.alu_op;
   assign PC_Write  = ctl_out.pc_write;
   assign PC0_Write = ctl_out.pc0_write;
   assign IR_Write  = ctl_out.ir_write;
   assign AB_Write  = ctl_out.ab_write;
   assign F_Write   = ctl_out.f_write;
   assign MDR_Write = ctl_out.mdr_write;
   assign Reg_Write = ctl_out.reg_write;
   assign Mem_Write = ctl_out.mem_write;
   assign rs2_imm_s = ctl_out.rs2_imm_s;
   assign alu_a_s   = ctl_out.alu_a_s;
   assign w_data_s  = ctl_out.w_data_s;
   assign PC_s      = ctl_out.pc_s;
   assign HALT      = ctl_out.halt;
   assign DBG_STATE = state;

endmodule
